// File: rtl/apb_mem_slave_if.sv
// APB4 signal bundle between a requester and the apb_mem_slave completer.
interface apb_mem_slave_if #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
);
  logic [addrWidth-1:0]     paddr;
  logic                     pwrite;
  logic                     psel;
  logic                     penable;
  logic [dataWidth-1:0]     pwdata;
  logic [dataWidth/8-1:0]   pstrb;
  logic [dataWidth-1:0]     prdata;
  logic                     pready;
  logic                     pslverr;

  // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
  // access cycles (psel=1, penable=1); it completes on the rising edge where
  // pready=1, and dropping psel during access aborts it with no side effects.
  modport master (
    output paddr, pwrite, psel, penable, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 completer in front of a word-addressed memory with programmable wait
// states, byte strobes, error response and abort on psel drop.
module apb_mem_slave #(
  parameter int addrWidth  = 32,
  parameter int dataWidth  = 32,
  parameter int memDepth   = 256,
  parameter int waitStates = 0
) (
  input  logic               clk,
  input  logic               rst,
  apb_mem_slave_if.slave     bus,
  output logic               state_dbg
);
  localparam int NB  = dataWidth / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = addrWidth - LSB;
  localparam int MW  = $clog2(memDepth);
  localparam int CW  = (waitStates > 0) ? $clog2(waitStates + 1) : 1;
  localparam logic [addrWidth-1:0] ALIGN_MASK = addrWidth'(NB - 1);
  localparam logic [IW:0]          DEPTH      = (IW + 1)'(memDepth);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   pready_q, pready_nxt;
  logic                   pslverr_q, pslverr_nxt;
  logic [dataWidth-1:0]   prdata_q, prdata_nxt;
  logic                   capture, mem_we;

  logic [addrWidth-1:0]   addr_q;
  logic                   write_q;
  logic [dataWidth-1:0]   wdata_q;
  logic [NB-1:0]          strb_q;

  logic [dataWidth-1:0]   mem [memDepth];

  // The setup cycle decodes the live bus; afterwards only the captured fields count.
  logic [addrWidth-1:0]   addr_sel;
  logic                   write_sel;
  logic [IW-1:0]          idx;
  logic                   err;
  logic [dataWidth-1:0]   rd_word;

  assign addr_sel  = (state == IDLE) ? bus.paddr  : addr_q;
  assign write_sel = (state == IDLE) ? bus.pwrite : write_q;
  assign idx       = addr_sel[addrWidth-1:LSB];
  assign err       = ((addr_sel & ALIGN_MASK) != '0) || ({1'b0, idx} >= DEPTH);
  assign rd_word   = (write_sel || err) ? '0 : mem[idx[MW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pready_q  <= pready_nxt;
      pslverr_q <= pslverr_nxt;
      prdata_q  <= prdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.psel && !bus.penable) state_nxt = ACCESS;
      ACCESS:  if (!bus.psel || (bus.penable && pready_q)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt     = cnt;
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    prdata_nxt  = '0;
    capture     = 1'b0;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          capture = 1'b1;
          cnt_nxt = CW'(waitStates);
          if (waitStates == 0) begin
            pready_nxt  = 1'b1;
            pslverr_nxt = err;
            prdata_nxt  = rd_word;
          end
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          cnt_nxt = '0;
        end else if (bus.penable) begin
          if (pready_q) begin
            // Reset on the completing edge wins over the write.
            mem_we = write_q && !err && !rst;
          end else begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == CW'(1)) begin
              pready_nxt  = 1'b1;
              pslverr_nxt = err;
              prdata_nxt  = rd_word;
            end
          end
        end else begin
          pready_nxt  = pready_q;
          pslverr_nxt = pslverr_q;
          prdata_nxt  = prdata_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= bus.paddr;
      write_q <= bus.pwrite;
      wdata_q <= bus.pwdata;
      strb_q  <= bus.pstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (strb_q[i]) mem[idx[MW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;
  assign state_dbg   = (state == ACCESS);
endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 2 and 3 wait states) sharing
// one driven bus, with psel routed to the selected instance.
module tb_apb_mem_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          dsel;

  int n_vec = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  apb_mem_slave_if #(.addrWidth(32), .dataWidth(32)) b0 ();
  apb_mem_slave_if #(.addrWidth(32), .dataWidth(32)) b2 ();
  apb_mem_slave_if #(.addrWidth(32), .dataWidth(32)) b3 ();
  logic st0, st2, st3;

  assign b0.paddr = paddr;  assign b0.pwrite = pwrite;  assign b0.penable = penable;
  assign b0.pwdata = pwdata; assign b0.pstrb = pstrb;   assign b0.psel = psel && (dsel == 0);
  assign b2.paddr = paddr;  assign b2.pwrite = pwrite;  assign b2.penable = penable;
  assign b2.pwdata = pwdata; assign b2.pstrb = pstrb;   assign b2.psel = psel && (dsel == 1);
  assign b3.paddr = paddr;  assign b3.pwrite = pwrite;  assign b3.penable = penable;
  assign b3.pwdata = pwdata; assign b3.pstrb = pstrb;   assign b3.psel = psel && (dsel == 2);

  apb_mem_slave #(.addrWidth(32), .dataWidth(32), .memDepth(256), .waitStates(0))
    u_ws0 (.clk(clk), .rst(rst), .bus(b0.slave), .state_dbg(st0));
  apb_mem_slave #(.addrWidth(32), .dataWidth(32), .memDepth(256), .waitStates(2))
    u_ws2 (.clk(clk), .rst(rst), .bus(b2.slave), .state_dbg(st2));
  apb_mem_slave #(.addrWidth(32), .dataWidth(32), .memDepth(256), .waitStates(3))
    u_ws3 (.clk(clk), .rst(rst), .bus(b3.slave), .state_dbg(st3));

  logic        pready_m, pslverr_m, st_m;
  logic [31:0] prdata_m;
  always_comb begin
    pready_m = b0.pready; pslverr_m = b0.pslverr; prdata_m = b0.prdata; st_m = st0;
    if (dsel == 1) begin
      pready_m = b2.pready; pslverr_m = b2.pslverr; prdata_m = b2.prdata; st_m = st2;
    end else if (dsel == 2) begin
      pready_m = b3.pready; pslverr_m = b3.pslverr; prdata_m = b3.prdata; st_m = st3;
    end
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One full transfer on instance k; expected {pslverr, prdata} goes through exp_q.
  task automatic xfer(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [32:0] e);
    int n;
    logic [32:0] want;
    @(negedge clk);
    dsel = k;
    check("pready_before_setup", {63'd0, pready_m}, 64'd0);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    exp_q.push_back(e);
    @(negedge clk);
    penable = 1'b1;
    // Bus fields wander during access; the captured ones must be used.
    paddr = a ^ 32'h4; pwdata = ~d; pstrb = ~s; pwrite = ~w;
    n = 1;
    while (!pready_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    want = exp_q.pop_front();
    if (!pready_m) begin
      n_vec++; n_bad++;
      $display("FAIL pready_timeout: no pready after %0d access cycles, expected %0d", n, ws_of(k) + 1);
    end else begin
      check("response", {31'd0, pslverr_m, prdata_m}, {31'd0, want});
      check("latency", 64'(n), 64'(ws_of(k) + 1));
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic [31:0] word_addr, d1, d2, model;
    logic [3:0]  s2;

    vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 1'b0, 32'h11BB33DD};
    vt[5]  = '{1'b0, 32'h400, 32'h0,        4'h0, 1'b1, 32'h0};
    vt[6]  = '{1'b1, 32'h12,  32'h99999999, 4'hF, 1'b1, 32'h0};
    vt[7]  = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    vt[8]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h3FC, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D};
    vt[10] = '{1'b1, 32'h24,  32'h01020304, 4'hF, 1'b0, 32'h0};
    vt[11] = '{1'b1, 32'h24,  32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
    vt[12] = '{1'b0, 32'h24,  32'h0,        4'h0, 1'b0, 32'h01020304};
    vt[13] = '{1'b1, 32'h20,  32'h99000000, 4'h8, 1'b0, 32'h0};
    vt[14] = '{1'b0, 32'h20,  32'h0,        4'h0, 1'b0, 32'h99BB33DD};
    vt[15] = '{1'b0, 32'h13,  32'h0,        4'h0, 1'b1, 32'h0};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; dsel = 0;
    repeat (3) @(negedge clk);
    check("reset_ws0", {29'd0, b0.pready, b0.pslverr, st0, b0.prdata}, 64'd0);
    check("reset_ws2", {29'd0, b2.pready, b2.pslverr, st2, b2.prdata}, 64'd0);
    check("reset_ws3", {29'd0, b3.pready, b3.pslverr, st3, b3.prdata}, 64'd0);
    rst = 1'b0;

    // Table vectors, back-to-back on the zero-wait instance.
    for (int i = 0; i < 16; i++)
      xfer(0, vt[i].w, vt[i].addr, vt[i].wdata, vt[i].strb, {vt[i].err, vt[i].rdata});
    go_idle();

    // Random fill / partial write / readback on words 64..127.
    for (int i = 0; i < 6; i++) begin
      word_addr = 32'($urandom_range(64, 127)) << 2;
      d1 = $urandom; d2 = $urandom; s2 = 4'($urandom_range(0, 15));
      model = merge(d1, d2, s2);
      xfer(0, 1'b1, word_addr, d1, 4'hF, 33'd0);
      xfer(0, 1'b1, word_addr, d2, s2, 33'd0);
      xfer(0, 1'b0, word_addr, 32'h0, 4'h0, {1'b0, model});
    end
    go_idle();

    // Three wait states: pready low for 3 access cycles, high on the 4th.
    xfer(2, 1'b1, 32'h04, 32'h0BADF00D, 4'hF, 33'd0);
    xfer(2, 1'b0, 32'h04, 32'h0, 4'h0, {1'b0, 32'h0BADF00D});
    xfer(2, 1'b0, 32'h400, 32'h0, 4'h0, {1'b1, 32'h0});
    go_idle();

    // Abort on the two-wait instance.
    xfer(1, 1'b1, 32'h08, 32'h12345678, 4'hF, 33'd0);
    @(negedge clk);
    dsel = 1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h55; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    check("abort_access1_pready", {63'd0, pready_m}, 64'd0);
    @(negedge clk);
    check("abort_access2_pready", {63'd0, pready_m}, 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort_idle", {62'd0, pready_m, st_m}, 64'd0);
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, {1'b0, 32'h12345678});
    xfer(1, 1'b1, 32'h0C, 32'hA5A5A5A5, 4'hF, 33'd0);
    xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, {1'b0, 32'hA5A5A5A5});
    xfer(1, 1'b1, 32'h10, 32'h5A5A5A5A, 4'h3, 33'd0);
    xfer(1, 1'b1, 32'h10, 32'hFFFF0000, 4'hC, 33'd0);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, {1'b0, 32'hFFFF5A5A});
    go_idle();

    // Reset on the completing edge of a write on the zero-wait instance.
    @(negedge clk);
    dsel = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55AA55AA; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    check("rst_pre_pready", {63'd0, pready_m}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", {29'd0, pready_m, pslverr_m, st_m, prdata_m}, 64'd0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF});
    go_idle();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
